flag_unit: RTL and testbench

- Consumer end of the ALU status interface. Captures the ALU's C/Z/N/V/S flags into an architectural status register (SREG) and evaluates branch conditions against it.
- Supports explicit flag set/clear instructions, in the AVR SEC/CLZ style.
- Supports a shadow stack so SREG can be saved on interrupt entry and restored on return.
- Sits between the ALU flag outputs and the fetch/branch logic.

---
 rtl/flag_unit.sv | 123 ++++++++++++
 tb/tb_flag_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// flag_unit: architectural status register (SREG) fed by ALU flags, explicit
// per-flag set/clear, a shadow stack for interrupt save/restore, and a
// combinational branch-condition evaluator on the registered SREG.
module flag_unit #(
  parameter int STACK_DEPTH = 4,
  parameter int DEPTH_W     = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alu_valid,
  input  logic [4:0]         alu_flags,
  input  logic [4:0]         flag_mask,
  input  logic               set_en,
  input  logic               clr_en,
  input  logic [2:0]         flag_sel,
  input  logic               push,
  input  logic               pop,
  input  logic               err_clr,
  input  logic [3:0]         cond,
  output logic [4:0]         sreg,
  output logic               branch_taken,
  output logic [DEPTH_W-1:0] stack_depth,
  output logic               stack_err
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] FULL_LVL = DEPTH_W'(STACK_DEPTH);

  // flag bit positions within sreg
  localparam int C_B = 0;
  localparam int Z_B = 1;
  localparam int N_B = 2;
  localparam int V_B = 3;
  localparam int S_B = 4;

  logic [4:0]         sreg_q, sreg_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q;
  logic [4:0]         stack_mem [STACK_DEPTH];

  logic               is_full, is_empty;
  logic               do_push, do_pop, err_evt;
  logic [DEPTH_W-1:0] top_ptr;
  logic [IDX_W-1:0]   wr_idx, rd_idx;

  assign is_full  = (depth_q == FULL_LVL);
  assign is_empty = (depth_q == '0);
  // a simultaneous push and pop is treated as a conflict: neither is performed
  assign do_push  = push & ~pop & ~is_full;
  assign do_pop   = pop & ~push & ~is_empty;
  assign err_evt  = (push & pop) | (push & ~pop & is_full) | (pop & ~push & is_empty);
  assign top_ptr  = depth_q - DEPTH_W'(1);
  assign wr_idx   = depth_q[IDX_W-1:0];
  assign rd_idx   = top_ptr[IDX_W-1:0];

  // SREG next-state: pop restore > set/clear > masked ALU update
  always_comb begin
    sreg_d = sreg_q;
    if (do_pop) begin
      sreg_d = stack_mem[rd_idx];
    end else if (set_en || clr_en) begin
      // out-of-range selector is a no-op but still blocks the ALU update
      if (flag_sel <= 3'd4) sreg_d[flag_sel] = set_en;
    end else if (alu_valid) begin
      sreg_d = (sreg_q & ~flag_mask) | (alu_flags & flag_mask);
    end
  end

  // stack occupancy next-state
  always_comb begin
    depth_d = depth_q;
    if (do_push)     depth_d = depth_q + DEPTH_W'(1);
    else if (do_pop) depth_d = top_ptr;
  end

  // state registers with synchronous reset; new errors override err_clr
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q  <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      depth_q <= depth_d;
      if (err_evt)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  // shadow stack storage; the pushed value is the pre-edge sreg
  always_ff @(posedge clk) begin
    if (!reset && do_push) stack_mem[wr_idx] <= sreg_q;
  end

  // branch condition evaluation; S is used as stored, never derived from N^V
  always_comb begin
    branch_taken = 1'b0;
    case (cond)
      4'd0:  branch_taken = 1'b1;
      4'd1:  branch_taken = 1'b0;
      4'd2:  branch_taken = sreg_q[Z_B];
      4'd3:  branch_taken = ~sreg_q[Z_B];
      4'd4:  branch_taken = sreg_q[C_B];
      4'd5:  branch_taken = ~sreg_q[C_B];
      4'd6:  branch_taken = sreg_q[N_B];
      4'd7:  branch_taken = ~sreg_q[N_B];
      4'd8:  branch_taken = sreg_q[V_B];
      4'd9:  branch_taken = ~sreg_q[V_B];
      4'd10: branch_taken = sreg_q[S_B];
      4'd11: branch_taken = ~sreg_q[S_B];
      4'd12: branch_taken = ~sreg_q[Z_B] & ~sreg_q[S_B];
      4'd13: branch_taken = sreg_q[Z_B] | sreg_q[S_B];
      4'd14: branch_taken = ~sreg_q[C_B] & ~sreg_q[Z_B];
      4'd15: branch_taken = sreg_q[C_B] | sreg_q[Z_B];
      default: branch_taken = 1'b0;
    endcase
  end

  assign sreg        = sreg_q;
  assign stack_depth = depth_q;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: each vector carries hand-computed expected
// post-edge state, queued by the driver and checked by a negedge monitor.
module tb_flag_unit;

  logic       clk = 1'b0;
  logic       reset, alu_valid, set_en, clr_en, push, pop, err_clr;
  logic [4:0] alu_flags, flag_mask;
  logic [2:0] flag_sel;
  logic [3:0] cond;
  logic [4:0] sreg;
  logic       branch_taken;
  logic [4:0] stack_depth;
  logic       stack_err;

  flag_unit #(.STACK_DEPTH(4), .DEPTH_W(5)) dut (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_flags(alu_flags),
    .flag_mask(flag_mask), .set_en(set_en), .clr_en(clr_en), .flag_sel(flag_sel),
    .push(push), .pop(pop), .err_clr(err_clr), .cond(cond), .sreg(sreg),
    .branch_taken(branch_taken), .stack_depth(stack_depth), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         step;
    logic [4:0] s;
    logic [4:0] d;
    logic       e;
    logic       b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_no = 0;

  // monitor: compare one queued expectation per negedge
  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_cmp += 4;
      if (sreg !== x.s) begin
        n_bad++; $display("FAIL step %0d sreg: got %h want %h", x.step, sreg, x.s);
      end
      if (stack_depth !== x.d) begin
        n_bad++; $display("FAIL step %0d depth: got %0d want %0d", x.step, stack_depth, x.d);
      end
      if (stack_err !== x.e) begin
        n_bad++; $display("FAIL step %0d stack_err: got %b want %b", x.step, stack_err, x.e);
      end
      if (branch_taken !== x.b) begin
        n_bad++; $display("FAIL step %0d branch cond=%0d: got %b want %b", x.step, cond, branch_taken, x.b);
      end
    end
  end

  // one cycle: r av flags mask set clr sel push pop errclr cond | exp sreg depth err br
  task automatic cyc(input logic r, input logic av, input logic [4:0] fl, input logic [4:0] mk,
                     input logic se, input logic ce, input logic [2:0] fs,
                     input logic pu, input logic po, input logic ec, input logic [3:0] cd,
                     input logic [4:0] es, input logic [4:0] ed, input logic ee, input logic eb);
    exp_t x;
    @(negedge clk); #2;
    reset = r; alu_valid = av; alu_flags = fl; flag_mask = mk;
    set_en = se; clr_en = ce; flag_sel = fs;
    push = pu; pop = po; err_clr = ec; cond = cd;
    @(posedge clk); #1;
    x.step = step_no; x.s = es; x.d = ed; x.e = ee; x.b = eb;
    exp_q.push_back(x);
    step_no++;
  endtask

  logic [15:0] sweep_tbl [6];
  logic [4:0]  sweep_val [6];

  initial begin
    logic [15:0] t;
    reset = 1'b1; alu_valid = 0; alu_flags = 0; flag_mask = 0; set_en = 0; clr_en = 0;
    flag_sel = 0; push = 0; pop = 0; err_clr = 0; cond = 0;

    // reset, and reset priority over an ALU update
    cyc(1,0,5'h00,5'h00,0,0,0,0,0,0, 0, 5'h00,0,0,1);
    cyc(1,1,5'h1f,5'h1f,0,0,0,1,0,0, 1, 5'h00,0,0,0);
    // basic ALU capture and EQ/NE
    cyc(0,1,5'h03,5'h1f,0,0,0,0,0,0, 2, 5'h03,0,0,1);
    cyc(0,0,5'h00,5'h00,0,0,0,0,0,0, 3, 5'h03,0,0,0);
    // masked update and set/clear priority
    cyc(0,1,5'h1f,5'h1f,0,0,0,0,0,0, 4, 5'h1f,0,0,1);
    cyc(0,1,5'h00,5'h05,0,0,0,0,0,0, 5, 5'h1a,0,0,1);
    cyc(0,1,5'h1f,5'h1f,0,0,0,0,0,0, 0, 5'h1f,0,0,1);
    cyc(0,1,5'h00,5'h05,1,0,1,0,0,0, 2, 5'h1f,0,0,1);
    cyc(0,1,5'h1f,5'h1f,0,1,1,0,0,0, 3, 5'h1d,0,0,1);
    cyc(0,0,5'h00,5'h00,1,1,1,0,0,0, 2, 5'h1f,0,0,1);
    cyc(0,1,5'h00,5'h1f,0,1,5,0,0,0, 6, 5'h1f,0,0,1);
    cyc(0,0,5'h00,5'h00,0,1,4,0,0,0,10, 5'h0f,0,0,0);
    cyc(0,1,5'h00,5'h1f,1,0,7,0,0,0,11, 5'h0f,0,0,1);
    // fill the stack with 01,02,04,08
    cyc(0,1,5'h01,5'h1f,0,0,0,0,0,0, 4, 5'h01,0,0,1);
    cyc(0,1,5'h02,5'h1f,0,0,0,1,0,0, 0, 5'h02,1,0,1);
    cyc(0,1,5'h04,5'h1f,0,0,0,1,0,0, 0, 5'h04,2,0,1);
    cyc(0,1,5'h08,5'h1f,0,0,0,1,0,0, 0, 5'h08,3,0,1);
    cyc(0,0,5'h00,5'h00,0,0,0,1,0,0, 0, 5'h08,4,0,1);
    // overflow: error, depth holds, ALU still updates
    cyc(0,1,5'h10,5'h1f,0,0,0,1,0,0,10, 5'h10,4,1,1);
    // pops restore in LIFO order and override set/ALU
    cyc(0,0,5'h00,5'h00,0,0,0,0,1,0, 8, 5'h08,3,1,1);
    cyc(0,1,5'h1f,5'h1f,0,0,0,0,1,0, 6, 5'h04,2,1,1);
    cyc(0,0,5'h00,5'h00,1,0,0,0,1,0, 4, 5'h02,1,1,0);
    cyc(0,0,5'h00,5'h00,0,0,0,0,1,0, 4, 5'h01,0,1,1);
    // underflow
    cyc(0,0,5'h00,5'h00,0,0,0,0,1,0,15, 5'h01,0,1,1);
    cyc(0,1,5'h04,5'h1f,0,0,0,0,1,0, 7, 5'h04,0,1,0);
    cyc(0,0,5'h00,5'h00,0,0,0,0,0,1, 1, 5'h04,0,0,0);
    // err_clr loses to a same-cycle conflict
    cyc(0,0,5'h00,5'h00,0,0,0,1,1,1, 0, 5'h04,0,1,1);
    cyc(0,0,5'h00,5'h00,0,0,0,0,0,1, 0, 5'h04,0,0,1);
    // push saves the pre-edge value while ALU changes sreg
    cyc(0,1,5'h00,5'h1f,0,0,0,0,0,0,14, 5'h00,0,0,1);
    cyc(0,1,5'h1f,5'h1f,0,0,0,1,0,0,12, 5'h1f,1,0,0);
    cyc(0,0,5'h00,5'h00,0,0,0,1,0,0,13, 5'h1f,2,0,1);
    cyc(0,1,5'h03,5'h1f,0,0,0,1,1,0,15, 5'h03,2,1,1);
    cyc(0,0,5'h00,5'h00,0,0,0,0,1,0, 9, 5'h1f,1,1,0);
    cyc(0,0,5'h00,5'h00,0,0,0,0,1,0,14, 5'h00,0,1,1);
    cyc(0,0,5'h00,5'h00,0,0,0,0,0,1, 0, 5'h00,0,0,1);

    // condition sweep; bit c of the table is the expected result for cond c
    sweep_val[0] = 5'h00; sweep_tbl[0] = 16'h5AA9;
    sweep_val[1] = 5'h01; sweep_tbl[1] = 16'h9A99;
    sweep_val[2] = 5'h02; sweep_tbl[2] = 16'hAAA5;
    sweep_val[3] = 5'h10; sweep_tbl[3] = 16'h66A9;
    sweep_val[4] = 5'h03; sweep_tbl[4] = 16'hAA95;
    sweep_val[5] = 5'h04; sweep_tbl[5] = 16'h5A69;
    for (int k = 0; k < 6; k++) begin
      t = sweep_tbl[k];
      cyc(0,1,sweep_val[k],5'h1f,0,0,0,0,0,0, 0, sweep_val[k],0,0,1);
      for (int c = 0; c < 16; c++)
        cyc(0,0,5'h00,5'h00,0,0,0,0,0,0, 4'(c), sweep_val[k],0,0,t[c]);
    end

    // reset mid-sequence discards stack and error
    cyc(0,1,5'h15,5'h1f,0,0,0,0,0,0, 0, 5'h15,0,0,1);
    cyc(0,0,5'h00,5'h00,0,0,0,1,0,0, 0, 5'h15,1,0,1);
    cyc(0,0,5'h00,5'h00,0,0,0,1,0,0, 0, 5'h15,2,0,1);
    cyc(0,0,5'h00,5'h00,0,0,0,1,1,0, 0, 5'h15,2,1,1);
    cyc(0,0,5'h00,5'h00,0,0,0,1,0,0, 0, 5'h15,3,1,1);
    cyc(1,0,5'h00,5'h00,0,0,0,1,0,0, 0, 5'h00,0,0,1);
    cyc(0,0,5'h00,5'h00,0,0,0,0,1,0, 0, 5'h00,0,1,1);
    cyc(0,0,5'h00,5'h00,0,0,0,0,0,0, 0, 5'h00,0,1,1);

    repeat (3) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
